jtag_tap_multi: RTL and testbench
=================================

Name: jtag_tap_multi

Overview:
Parametrised JTAG TAP controller: the next generation of the single-chain tap. It has a configurable IR width, a configurable IDCODE and a user data register of configurable width. It steers up to NUM_CHAINS external boundary-scan chains through a chain-select register. It sits directly under the tt_um_* top wrapper, with clk used as TCK; all outputs drive pins or external BSR cells.

Parameters:
IR_WIDTH, 4, instruction register length (>=2)
IDCODE_VAL, 32'h1000_0001, value captured by IDCODE (bit 0 must be 1)
USER_WIDTH, 8, width of USER data register
NUM_CHAINS, 2, number of external boundary chains (1..8)
CSEL_W, 3, chain-select DR width; must satisfy 2**CSEL_W >= NUM_CHAINS

Ports:
clk  in  1  TCK; all state changes on rising edge
rst_n  in  1  synchronous active-low reset
tms  in  1  test mode select
tdi  in  1  test data in
tdo  out  1  test data out
tdo_en  out  1  high in Shift-IR/Shift-DR
bsr_tdo  in  NUM_CHAINS  serial return from each chain
bsr_tdi  out  1  serial data to chains (mirrors tdi)
bsr_sel  out  NUM_CHAINS  one-hot active chain
bsr_capture  out  1  capture strobe to selected chain
bsr_shift  out  1  shift enable to selected chain
bsr_update  out  1  update strobe to selected chain
bsr_mode  out  1  1 = EXTEST drive mode
user_dr  out  USER_WIDTH  latched USER register
user_upd  out  1  one-cycle pulse when user_dr updates
dm_reset  out  1  debug-module reset, level

Behaviour:
- Reset (rst_n=0 at rising edge), or TMS=1 for 5 consecutive edges, forces Test-Logic-Reset (TLR).
- TLR sets IR=IDCODE, chain_sel=0, user_dr=0 and dm_reset=0.
- Reset values: tdo=0, tdo_en=0, bsr_sel=1 (chain 0), all strobes 0, bsr_mode=0, user_upd=0.
- Reset mid-shift abandons the shift. No update occurs and no strobe is emitted.
- TAP FSM: the 16 IEEE 1149.1 states, with transitions on tms per the standard graph.
- Capture-IR loads {IR_WIDTH-2 zeros, 2'b01}.
- Shift states: the selected register shifts right each edge; tdi enters at the MSB.
- tdo = LSB of the selected register (combinational from registers) while in a shift state, else 0. tdo_en follows the same condition.
- Update-IR: IR is loaded from the shift register on the edge leaving Update-IR.
- Instruction decode (IR_WIDTH=4 codes; generalised by zero-extension, BYPASS is all-ones):
  - EXTEST=0: DR is the selected chain. bsr_mode=1 from Update-IR until the next Update-IR or TLR.
  - IDCODE=1: 32-bit DR, Capture-DR loads IDCODE_VAL.
  - SAMPLE=2: DR is the selected chain, bsr_mode=0.
  - USER=8: USER_WIDTH DR. Capture loads the current user_dr. Update-DR latches user_dr and pulses user_upd for 1 cycle.
  - CSEL=9: CSEL_W DR. Update-DR latches chain_sel.
  - DMRST=10: 1-bit DR. Update-DR sets dm_reset=bit.
  - All other codes, and BYPASS: 1-bit DR, captures 0.
- Chain DR path:
  - bsr_capture=1 in Capture-DR, bsr_shift=1 in Shift-DR, bsr_update=1 in Update-DR, each only under EXTEST/SAMPLE.
  - tdo = bsr_tdo[chain_sel].
- A chain_sel value >= NUM_CHAINS is clamped to NUM_CHAINS-1 when latched.
- bsr_sel is one-hot of chain_sel and changes only on Update-DR of CSEL.
- A Pause/Exit2 round-trip preserves shift contents.
- Update-DR without an intervening Shift still latches the captured value.

Decomposition:
- Package jtag_pkg holds:
  - tap_state_t enum (16 states)
  - instruction code constants (EXTEST, IDCODE, SAMPLE, USER, CSEL, DMRST, BYPASS)
  - the IR capture pattern
- Sub-module jtag_tap_fsm contains the state register plus next-state logic and decoded state flags.
- jtag_tap_multi contains the IR, DR muxing and outputs.

Test Plan:
- rst_n=0 for one edge, then TMS=1 for 5 edges from Shift-DR → TLR; bsr_sel=2'b01, dm_reset=0, tdo_en=0.
- From TLR go to Shift-DR and shift 32 bits → tdo stream LSB-first equals 32'h1000_0001.
- Shift-IR 4 bits with tdi=1111, then Update; shift DR pattern 1,0,1,1 → tdo shows 0 then the pattern delayed one bit. The first 4 tdo bits during Shift-IR are 1,0,0,0 (capture 0001 LSB-first).
- IR=USER, shift 8'hA5 then Update-DR → user_dr=8'hA5, user_upd high exactly 1 cycle. Recapture returns A5 on tdo.
- IR=CSEL, shift 3'd5 with NUM_CHAINS=2 → bsr_sel=2'b10. Then IR=EXTEST → bsr_mode=1. Shift-DR → bsr_shift=1 and tdo follows bsr_tdo[1].
- IR=USER, rst_n=0 mid Shift-DR after 3 bits → user_dr stays 0, user_upd never pulses, IR reads back IDCODE.

Source files
------------

// File: rtl/jtag_pkg.sv
// -----------------------------------------------------------------------------
// jtag_pkg
// Shared types and constants for the multi-chain JTAG TAP:
//   tap_state_t  - the 16 IEEE 1149.1 TAP controller states
//   CODE_*       - instruction codes (zero-extended to IR_WIDTH by the user;
//                  BYPASS is all-ones at whatever IR_WIDTH is in use)
//   instr_t      - decoded instruction
//   tap_flags_t  - decoded state strobes handed from the FSM to the datapath
//   IR_CAPTURE_LSBS - low bits loaded into the IR shifter in Capture-IR
// -----------------------------------------------------------------------------
package jtag_pkg;

  typedef enum logic [3:0] {
    ST_TLR,
    ST_RTI,
    ST_SEL_DR,
    ST_CAP_DR,
    ST_SHIFT_DR,
    ST_EXIT1_DR,
    ST_PAUSE_DR,
    ST_EXIT2_DR,
    ST_UPD_DR,
    ST_SEL_IR,
    ST_CAP_IR,
    ST_SHIFT_IR,
    ST_EXIT1_IR,
    ST_PAUSE_IR,
    ST_EXIT2_IR,
    ST_UPD_IR
  } tap_state_t;

  // Instruction codes as 32-bit values; the IR is zero-extended before compare.
  localparam logic [31:0] CODE_EXTEST = 32'd0;
  localparam logic [31:0] CODE_IDCODE = 32'd1;
  localparam logic [31:0] CODE_SAMPLE = 32'd2;
  localparam logic [31:0] CODE_USER   = 32'd8;
  localparam logic [31:0] CODE_CSEL   = 32'd9;
  localparam logic [31:0] CODE_DMRST  = 32'd10;
  // All-ones; truncated to IR_WIDTH where used.
  localparam logic [31:0] CODE_BYPASS = 32'hFFFF_FFFF;

  // Capture-IR loads {zeros, 2'b01}.
  localparam logic [1:0] IR_CAPTURE_LSBS = 2'b01;

  typedef enum logic [2:0] {
    INS_EXTEST,
    INS_IDCODE,
    INS_SAMPLE,
    INS_USER,
    INS_CSEL,
    INS_DMRST,
    INS_BYPASS
  } instr_t;

  typedef struct packed {
    logic goto_tlr;    // next state is Test-Logic-Reset
    logic capture_dr;
    logic shift_dr;
    logic update_dr;
    logic capture_ir;
    logic shift_ir;
    logic update_ir;
  } tap_flags_t;

  // Instructions whose data register is the external boundary chain.
  function automatic logic is_chain_instr(input instr_t ins);
    return (ins == INS_EXTEST) || (ins == INS_SAMPLE);
  endfunction

endpackage

// File: rtl/jtag_tap_multi_if.sv
// -----------------------------------------------------------------------------
// jtag_tap_multi_if
// Pin-level bundle of the multi-chain TAP.
//   tms, tdi, tdo, tdo_en          - JTAG serial port
//   bsr_tdo/bsr_tdi/bsr_sel/...    - boundary-scan chain control
//   user_dr, user_upd, dm_reset    - user-facing register outputs
// Modport slave is the TAP side, master is the host/board side.
// -----------------------------------------------------------------------------
interface jtag_tap_multi_if #(
  parameter int NUM_CHAINS = 2,
  parameter int USER_WIDTH = 8
);
  logic                  tms;
  logic                  tdi;
  logic                  tdo;
  logic                  tdo_en;
  logic [NUM_CHAINS-1:0] bsr_tdo;
  logic                  bsr_tdi;
  logic [NUM_CHAINS-1:0] bsr_sel;
  logic                  bsr_capture;
  logic                  bsr_shift;
  logic                  bsr_update;
  logic                  bsr_mode;
  logic [USER_WIDTH-1:0] user_dr;
  logic                  user_upd;
  logic                  dm_reset;

  modport slave (
    input  tms, tdi, bsr_tdo,
    output tdo, tdo_en, bsr_tdi, bsr_sel, bsr_capture, bsr_shift,
           bsr_update, bsr_mode, user_dr, user_upd, dm_reset
  );

  modport master (
    output tms, tdi, bsr_tdo,
    input  tdo, tdo_en, bsr_tdi, bsr_sel, bsr_capture, bsr_shift,
           bsr_update, bsr_mode, user_dr, user_upd, dm_reset
  );
endinterface

// File: rtl/jtag_tap_fsm.sv
// -----------------------------------------------------------------------------
// jtag_tap_fsm
// IEEE 1149.1 TAP controller state machine.
//   clk    - TCK
//   rst_n  - synchronous active-low reset, forces Test-Logic-Reset
//   tms    - test mode select
//   flags  - decoded state strobes (capture/shift/update for IR and DR) plus
//            goto_tlr, which is high on any edge that lands in TLR so the
//            datapath can apply TLR defaults on that same edge
// -----------------------------------------------------------------------------
module jtag_tap_fsm
  import jtag_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tms,
  output tap_flags_t flags
);

  tap_state_t state_q, state_d;

  // NOTE: reset is sampled on the clock edge (synchronous); state flops use
  // non-blocking assignments so all flops see pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_TLR;
    else        state_q <= state_d;
  end

  // NOTE: state_d gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_TLR:      state_d = tms ? ST_TLR      : ST_RTI;
      ST_RTI:      state_d = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_DR:   state_d = tms ? ST_SEL_IR   : ST_CAP_DR;
      ST_CAP_DR:   state_d = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_SHIFT_DR: state_d = tms ? ST_EXIT1_DR : ST_SHIFT_DR;
      ST_EXIT1_DR: state_d = tms ? ST_UPD_DR   : ST_PAUSE_DR;
      ST_PAUSE_DR: state_d = tms ? ST_EXIT2_DR : ST_PAUSE_DR;
      ST_EXIT2_DR: state_d = tms ? ST_UPD_DR   : ST_SHIFT_DR;
      ST_UPD_DR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
      ST_SEL_IR:   state_d = tms ? ST_TLR      : ST_CAP_IR;
      ST_CAP_IR:   state_d = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_SHIFT_IR: state_d = tms ? ST_EXIT1_IR : ST_SHIFT_IR;
      ST_EXIT1_IR: state_d = tms ? ST_UPD_IR   : ST_PAUSE_IR;
      ST_PAUSE_IR: state_d = tms ? ST_EXIT2_IR : ST_PAUSE_IR;
      ST_EXIT2_IR: state_d = tms ? ST_UPD_IR   : ST_SHIFT_IR;
      ST_UPD_IR:   state_d = tms ? ST_SEL_DR   : ST_RTI;
      default:     state_d = ST_TLR;
    endcase
  end

  always_comb begin
    flags            = '0;
    flags.goto_tlr   = (state_d == ST_TLR);
    flags.capture_dr = (state_q == ST_CAP_DR);
    flags.shift_dr   = (state_q == ST_SHIFT_DR);
    flags.update_dr  = (state_q == ST_UPD_DR);
    flags.capture_ir = (state_q == ST_CAP_IR);
    flags.shift_ir   = (state_q == ST_SHIFT_IR);
    flags.update_ir  = (state_q == ST_UPD_IR);
  end

endmodule

// File: rtl/jtag_tap_multi.sv
// -----------------------------------------------------------------------------
// jtag_tap_multi
// Parametrised JTAG TAP with IDCODE, USER, chain-select and debug-reset data
// registers, steering up to NUM_CHAINS external boundary-scan chains.
//   clk    - TCK; all state changes on rising edge
//   rst_n  - synchronous active-low reset
//   bus    - jtag_tap_multi_if.slave: tms/tdi/tdo/tdo_en, chain controls
//            (bsr_*), user_dr/user_upd and dm_reset
// All internal data registers share one shifter whose effective length is set
// by the current instruction: tdi is inserted at bit (length-1), tdo is bit 0.
// -----------------------------------------------------------------------------
module jtag_tap_multi
  import jtag_pkg::*;
#(
  parameter int          IR_WIDTH   = 4,
  parameter logic [31:0] IDCODE_VAL = 32'h1000_0001,
  parameter int          USER_WIDTH = 8,
  parameter int          NUM_CHAINS = 2,
  parameter int          CSEL_W     = 3
) (
  input logic              clk,
  input logic              rst_n,
  jtag_tap_multi_if.slave  bus
);

  // Shared DR shifter must hold the longest internal register.
  localparam int DR_MAX_UC = (USER_WIDTH > CSEL_W) ? USER_WIDTH : CSEL_W;
  localparam int DR_W      = (DR_MAX_UC > 32) ? DR_MAX_UC : 32;
  localparam int DR_IW     = $clog2(DR_W);

  tap_flags_t flags;

  jtag_tap_fsm u_fsm (
    .clk   (clk),
    .rst_n (rst_n),
    .tms   (bus.tms),
    .flags (flags)
  );

  logic [IR_WIDTH-1:0]   ir_q, ir_d;
  logic [IR_WIDTH-1:0]   ir_sr_q, ir_sr_d;
  logic [DR_W-1:0]       dr_sr_q, dr_sr_d;
  logic [CSEL_W-1:0]     chain_sel_q, chain_sel_d;
  logic [USER_WIDTH-1:0] user_dr_q, user_dr_d;
  logic                  user_upd_q, user_upd_d;
  logic                  dm_reset_q, dm_reset_d;

  instr_t                instr;
  logic                  chain_instr;
  logic [DR_IW-1:0]      dr_msb;
  logic [31:0]           ir_ext;
  logic [CSEL_W-1:0]     csel_new;
  logic                  chain_tdo;
  logic [NUM_CHAINS-1:0] bsr_sel_w;

  // Instruction decode and active DR length.
  always_comb begin
    ir_ext = 32'(ir_q);
    instr  = INS_BYPASS;
    if (ir_q != IR_WIDTH'(CODE_BYPASS)) begin
      case (ir_ext)
        CODE_EXTEST: instr = INS_EXTEST;
        CODE_IDCODE: instr = INS_IDCODE;
        CODE_SAMPLE: instr = INS_SAMPLE;
        CODE_USER:   instr = INS_USER;
        CODE_CSEL:   instr = INS_CSEL;
        CODE_DMRST:  instr = INS_DMRST;
        default:     instr = INS_BYPASS;
      endcase
    end
    case (instr)
      INS_IDCODE: dr_msb = DR_IW'(31);
      INS_USER:   dr_msb = DR_IW'(USER_WIDTH - 1);
      INS_CSEL:   dr_msb = DR_IW'(CSEL_W - 1);
      default:    dr_msb = '0;
    endcase
    chain_instr = is_chain_instr(instr);
  end

  // Chain select decode; chain_sel_q is always < NUM_CHAINS thanks to the
  // clamp applied when it is latched.
  always_comb begin
    chain_tdo = 1'b0;
    bsr_sel_w = '0;
    for (int i = 0; i < NUM_CHAINS; i++) begin
      if (chain_sel_q == CSEL_W'(i)) begin
        chain_tdo    = bus.bsr_tdo[i];
        bsr_sel_w[i] = 1'b1;
      end
    end
  end

  always_comb begin
    ir_d        = ir_q;
    ir_sr_d     = ir_sr_q;
    dr_sr_d     = dr_sr_q;
    chain_sel_d = chain_sel_q;
    user_dr_d   = user_dr_q;
    user_upd_d  = 1'b0;
    dm_reset_d  = dm_reset_q;

    csel_new = dr_sr_q[CSEL_W-1:0];
    if (csel_new > CSEL_W'(NUM_CHAINS - 1)) csel_new = CSEL_W'(NUM_CHAINS - 1);

    // IR path.
    if (flags.capture_ir) ir_sr_d = IR_WIDTH'(IR_CAPTURE_LSBS);
    if (flags.shift_ir)   ir_sr_d = {bus.tdi, ir_sr_q[IR_WIDTH-1:1]};
    if (flags.update_ir)  ir_d    = ir_sr_q;

    // DR path. Chain instructions leave the shifter idle; BYPASS and unknown
    // codes capture 0 into a 1-bit register.
    if (flags.capture_dr) begin
      dr_sr_d = '0;
      case (instr)
        INS_IDCODE: dr_sr_d[31:0]           = IDCODE_VAL;
        INS_USER:   dr_sr_d[USER_WIDTH-1:0] = user_dr_q;
        INS_CSEL:   dr_sr_d[CSEL_W-1:0]     = chain_sel_q;
        INS_DMRST:  dr_sr_d[0]              = dm_reset_q;
        default:    ;
      endcase
    end
    if (flags.shift_dr) begin
      dr_sr_d         = dr_sr_q >> 1;
      dr_sr_d[dr_msb] = bus.tdi;
    end
    if (flags.update_dr) begin
      case (instr)
        INS_USER: begin
          user_dr_d  = dr_sr_q[USER_WIDTH-1:0];
          user_upd_d = 1'b1;
        end
        INS_CSEL:  chain_sel_d = csel_new;
        INS_DMRST: dm_reset_d  = dr_sr_q[0];
        default:   ;
      endcase
    end

    // Entering or remaining in TLR restores the architectural defaults on
    // the same edge, so they are visible as soon as the FSM reads TLR.
    if (flags.goto_tlr) begin
      ir_d        = IR_WIDTH'(CODE_IDCODE);
      chain_sel_d = '0;
      user_dr_d   = '0;
      user_upd_d  = 1'b0;
      dm_reset_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ir_q        <= IR_WIDTH'(CODE_IDCODE);
      ir_sr_q     <= '0;
      dr_sr_q     <= '0;
      chain_sel_q <= '0;
      user_dr_q   <= '0;
      user_upd_q  <= 1'b0;
      dm_reset_q  <= 1'b0;
    end else begin
      ir_q        <= ir_d;
      ir_sr_q     <= ir_sr_d;
      dr_sr_q     <= dr_sr_d;
      chain_sel_q <= chain_sel_d;
      user_dr_q   <= user_dr_d;
      user_upd_q  <= user_upd_d;
      dm_reset_q  <= dm_reset_d;
    end
  end

  assign bus.tdo = flags.shift_ir ? ir_sr_q[0]
                 : flags.shift_dr ? (chain_instr ? chain_tdo : dr_sr_q[0])
                 : 1'b0;
  assign bus.tdo_en      = flags.shift_ir | flags.shift_dr;
  assign bus.bsr_tdi     = bus.tdi;
  assign bus.bsr_sel     = bsr_sel_w;
  assign bus.bsr_capture = flags.capture_dr & chain_instr;
  assign bus.bsr_shift   = flags.shift_dr   & chain_instr;
  assign bus.bsr_update  = flags.update_dr  & chain_instr;
  assign bus.bsr_mode    = (instr == INS_EXTEST);
  assign bus.user_dr     = user_dr_q;
  assign bus.user_upd    = user_upd_q;
  assign bus.dm_reset    = dm_reset_q;

endmodule

// File: tb/tb_jtag_tap_multi.sv
// -----------------------------------------------------------------------------
// tb_jtag_tap_multi
// Directed bench for jtag_tap_multi with default parameters (IR 4 bits,
// IDCODE 32'h1000_0001, USER 8 bits, 2 chains, CSEL 3 bits). Inputs change
// 1 time unit after each rising edge; outputs are sampled at that point too.
// -----------------------------------------------------------------------------
module tb_jtag_tap_multi;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  jtag_tap_multi_if #(.NUM_CHAINS(2), .USER_WIDTH(8)) bus ();

  jtag_tap_multi #(
    .IR_WIDTH   (4),
    .IDCODE_VAL (32'h1000_0001),
    .USER_WIDTH (8),
    .NUM_CHAINS (2),
    .CSEL_W     (3)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [63:0] dout;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic t, input logic d);
    bus.tms = t;
    bus.tdi = d;
    @(posedge clk);
    #1;
  endtask

  // Shift n bits LSB-first; TMS rises on the last bit so the FSM ends in Exit1.
  task automatic shift_bits(input int n, input logic [63:0] din, output logic [63:0] dq);
    logic [63:0] d;
    d  = din;
    dq = '0;
    for (int i = 0; i < n; i++) begin
      dq = dq | (64'(bus.tdo) << i);
      step(i == n - 1, d[0]);
      d = d >> 1;
    end
  endtask

  // Exit1 -> Update -> Run-Test/Idle.
  task automatic update();
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic goto_shift_dr();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic goto_shift_ir();
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
  endtask

  task automatic load_ir(input logic [3:0] code, output logic [63:0] cap);
    goto_shift_ir();
    shift_bits(4, 64'(code), cap);
    update();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst_n       = 1'b0;
    bus.tms     = 1'b1;
    bus.tdi     = 1'b0;
    bus.bsr_tdo = '0;
    step(1'b1, 1'b0);
    rst_n = 1'b1;

    // Reset state.
    check("rst_tdo",      64'(bus.tdo),      64'h0);
    check("rst_tdo_en",   64'(bus.tdo_en),   64'h0);
    check("rst_bsr_sel",  64'(bus.bsr_sel),  64'h1);
    check("rst_bsr_mode", 64'(bus.bsr_mode), 64'h0);
    check("rst_strobes",  64'({bus.bsr_capture, bus.bsr_shift, bus.bsr_update}), 64'h0);
    check("rst_user_dr",  64'(bus.user_dr),  64'h0);
    check("rst_user_upd", 64'(bus.user_upd), 64'h0);
    check("rst_dm_reset", 64'(bus.dm_reset), 64'h0);

    // Into Shift-DR, then five TMS=1 edges back to TLR.
    goto_shift_dr();
    check("shdr_tdo_en", 64'(bus.tdo_en), 64'h1);
    check("shdr_tdo0",   64'(bus.tdo),    64'h1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tms5_tdo_en", 64'(bus.tdo_en), 64'h0);

    // IDCODE read-out.
    goto_shift_dr();
    shift_bits(32, 64'h0, dout);
    check("idcode", dout, 64'h1000_0001);
    update();

    // IR capture pattern and BYPASS.
    load_ir(4'hF, dout);
    check("ir_capture", dout, 64'h1);
    goto_shift_dr();
    shift_bits(4, 64'hD, dout);
    check("bypass_stream", dout, 64'hA);
    update();

    // USER write, pulse, recapture.
    load_ir(4'h8, dout);
    goto_shift_dr();
    shift_bits(8, 64'hA5, dout);
    check("user_cap0", dout, 64'h0);
    step(1'b1, 1'b0);
    check("user_upd_in_upd", 64'(bus.user_upd), 64'h0);
    step(1'b0, 1'b0);
    check("user_dr_a5",  64'(bus.user_dr),  64'hA5);
    check("user_upd_hi", 64'(bus.user_upd), 64'h1);
    step(1'b0, 1'b0);
    check("user_upd_lo", 64'(bus.user_upd), 64'h0);
    goto_shift_dr();
    shift_bits(8, 64'hA5, dout);
    check("user_recap", dout, 64'hA5);
    update();

    // Pause/Exit2 round trip keeps the shifter contents.
    goto_shift_dr();
    shift_bits(4, 64'hC, dout);
    check("pause_part1", dout, 64'h5);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    shift_bits(4, 64'h3, dout);
    check("pause_part2", dout, 64'hA);
    update();
    check("pause_user_dr", 64'(bus.user_dr), 64'h3C);

    // Capture straight to Update still latches the captured value.
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("noshift_user_dr",  64'(bus.user_dr),  64'h3C);
    check("noshift_user_upd", 64'(bus.user_upd), 64'h1);

    // CSEL with out-of-range value clamps to the last chain.
    load_ir(4'h9, dout);
    goto_shift_dr();
    shift_bits(3, 64'h5, dout);
    check("csel_cap", dout, 64'h0);
    update();
    check("csel_bsr_sel", 64'(bus.bsr_sel), 64'h2);

    // EXTEST on chain 1.
    load_ir(4'h0, dout);
    check("extest_mode", 64'(bus.bsr_mode), 64'h1);
    check("extest_sel",  64'(bus.bsr_sel),  64'h2);
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    check("ext_capture", 64'(bus.bsr_capture), 64'h1);
    step(1'b0, 1'b0);
    check("ext_shift",   64'(bus.bsr_shift),   64'h1);
    check("ext_cap_off", 64'(bus.bsr_capture), 64'h0);
    bus.bsr_tdo = 2'b10;
    #1;
    check("ext_tdo_ch1_hi", 64'(bus.tdo), 64'h1);
    bus.bsr_tdo = 2'b01;
    #1;
    check("ext_tdo_ch1_lo", 64'(bus.tdo), 64'h0);
    bus.tdi = 1'b1;
    #1;
    check("bsr_tdi_mirror", 64'(bus.bsr_tdi), 64'h1);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("ext_update",    64'(bus.bsr_update), 64'h1);
    check("ext_shift_off", 64'(bus.bsr_shift),  64'h0);
    step(1'b0, 1'b0);
    check("ext_update_off", 64'(bus.bsr_update), 64'h0);
    check("ext_mode_kept",  64'(bus.bsr_mode),   64'h1);
    bus.bsr_tdo = '0;

    // SAMPLE drops drive mode.
    load_ir(4'h2, dout);
    check("sample_mode", 64'(bus.bsr_mode), 64'h0);

    // DMRST set, then TLR via TMS clears everything.
    load_ir(4'hA, dout);
    goto_shift_dr();
    shift_bits(1, 64'h1, dout);
    check("dmrst_cap", dout, 64'h0);
    update();
    check("dm_reset_set", 64'(bus.dm_reset), 64'h1);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
    check("tlr_dm_reset", 64'(bus.dm_reset), 64'h0);
    check("tlr_bsr_sel",  64'(bus.bsr_sel),  64'h1);
    check("tlr_bsr_mode", 64'(bus.bsr_mode), 64'h0);
    check("tlr_user_dr",  64'(bus.user_dr),  64'h0);
    check("tlr_tdo_en",   64'(bus.tdo_en),   64'h0);

    // Reset in the middle of a USER shift abandons it.
    load_ir(4'h8, dout);
    goto_shift_dr();
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    rst_n = 1'b0;
    step(1'b0, 1'b1);
    rst_n = 1'b1;
    check("midrst_user_upd", 64'(bus.user_upd), 64'h0);
    check("midrst_user_dr",  64'(bus.user_dr),  64'h0);
    check("midrst_tdo_en",   64'(bus.tdo_en),   64'h0);
    step(1'b1, 1'b0);
    check("midrst_user_upd2", 64'(bus.user_upd), 64'h0);
    goto_shift_dr();
    shift_bits(32, 64'h0, dout);
    check("midrst_idcode", dout, 64'h1000_0001);
    update();
    check("midrst_user_dr2", 64'(bus.user_dr), 64'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
